mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side end of the cache miss/store interface: the block that answers cache `mem_req`s.
- Arbitrates between the instruction cache (requester 0) and the data cache (requester 1), issuing `grant` to one at a time.
- After a fixed latency it returns a full line on `fill` with a one-cycle `mem_resp` pulse.
- Stores are write-through word writes into a line-organised backing array.
- Sits between the two L1 caches and the top-level memory model in the core.

Parameters:
- MEM_LATENCY, 5: cycles from grant cycle to resp cycle; legal range 2 to 15.
- MEM_LINES, 256: depth of the backing array in cache lines; must be a power of two.
- N_REQ, 2: number of requesters, fixed at 2 (0 = icache, 1 = dcache).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  in  [N_REQ-1:0]  per-requester request level.
- mem_instr  in  [N_REQ-1:0]  per-requester op: 0 = store, 1 = load.
- p_address  in  [N_REQ-1:0][TAG_BITS-1:0]  per-requester line address.
- word_sel  in  [N_REQ-1:0][$clog2(CACHE_LINE_LEN/REG_LEN)-1:0]  store word index within the line.
- wdata  in  [N_REQ-1:0][REG_LEN-1:0]  store data.
- grant  out  [N_REQ-1:0]  one-hot, request accepted this cycle.
- mem_resp  out  [N_REQ-1:0]  one-hot, one-cycle response pulse.
- fill  out  CACHE_LINE_LEN  line data, valid in the cycle `mem_resp` is high.

Behaviour:
- Reset values: `grant`=0, `mem_resp`=0, `fill`=0, FSM=IDLE, rr_ptr=0 (requester 0 has priority), counter=0. Array contents are not reset.
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - `grant` is combinational: it selects one requester with `mem_req` high, according to the round-robin arbiter.
  - On the grant edge the block captures mem_instr, p_address, word_sel, wdata and the requester id, then moves to BUSY with counter = MEM_LATENCY-2.
- Round-robin: after each grant, rr_ptr points to the other requester. Priority applies only when both requesters are high in the same cycle.
- BUSY:
  - `grant` is held at 0 and requests are ignored.
  - The counter decrements each cycle; at 0 the FSM moves to RESP.
  - With MEM_LATENCY=2, BUSY lasts exactly one cycle.
- RESP:
  - `mem_resp[id]`=1 for one cycle.
  - Load: `fill` = array[p_address mod MEM_LINES].
  - Store: `fill` = that line with word `word_sel` replaced by `wdata`. The array is written with the same merged line on this edge.
  - The next state is always IDLE.
- Latency: grant in cycle T gives resp in cycle T+MEM_LATENCY. The earliest next grant is at T+MEM_LATENCY+1.
- `fill` is registered and holds its last value between responses.
- Requester rule: hold `mem_req` until `grant`, then deassert it in the following cycle. A `mem_req` still high in the IDLE cycle after resp is treated as a new request.
- Address width: only the low $clog2(MEM_LINES) bits of p_address index the array; higher bits wrap.
- Reset mid-operation: the FSM returns to IDLE and no `mem_resp` is issued. A store still pending in BUSY is not committed to the array.
- `word_sel` and `wdata` are don't-care for loads.
- Load after store: a load granted after a store's resp returns the updated word.

Decomposition:
- Shared package (brisc_pkg):
  - add `mem_state_e` {IDLE, BUSY, RESP};
  - add constants MEM_LATENCY, MEM_LINES, WORDS_PER_LINE = CACHE_LINE_LEN/REG_LEN;
  - reuse the existing ADDRESS_BITS, CACHE_LINE_LEN, REG_LEN and BYTE_LEN;
  - add the load/store opcode constants for `mem_instr`.
- Sub-module `rr_arbiter2`: 2-input round-robin arbiter.
  - Ports: clk, rst_n, req[1:0], advance, gnt[1:0].
  - Stateful pointer that updates only when `advance` is asserted.

Test Plan:
Bench configuration: CACHE_LINE_LEN=128, REG_LEN=32, MEM_LATENCY=5, array preloaded with line k = {4{k}}.
- Single load: req0=1, load, addr=3 at cycle 10 → grant0 at 10; resp0 at 15 with fill=128'h00000003_00000003_00000003_00000003; no grant in cycles 11-15.
- Store then load: req1 store addr=7, word_sel=2, wdata=32'hDEADBEEF → resp1 fill has word2=DEADBEEF, others 7; a following load of addr 7 returns the same line.
- Contention: req0 and req1 both high from reset exit → grant0 first. If both are held, grant1 comes next, then grant0, strictly alternating; gap between grants is 6 cycles.
- Wrap: load addr = MEM_LINES+5 → fill equals line 5.
- Reset mid-op: store granted, rst_n low for 1 cycle during BUSY → no mem_resp; all outputs 0; a later load shows the old line unchanged; rr_ptr=0.
- MEM_LATENCY=2 build: grant at T, resp at T+2, next grant at T+3 with back-to-back requests.

Source files
------------

// File: rtl/brisc_pkg.sv
// Core-wide constants and types shared by the memory responder and its testbench.
package brisc_pkg;

   localparam int ADDRESS_BITS   = 32;
   localparam int REG_LEN        = 32;
   localparam int BYTE_LEN       = 8;
   localparam int CACHE_LINE_LEN = 128;

   localparam int WORDS_PER_LINE = CACHE_LINE_LEN / REG_LEN;
   localparam int WSEL_BITS      = $clog2(WORDS_PER_LINE);
   localparam int OFFSET_BITS    = $clog2(CACHE_LINE_LEN / BYTE_LEN);
   localparam int TAG_BITS       = ADDRESS_BITS - OFFSET_BITS;

   localparam int MEM_LATENCY    = 5;
   localparam int MEM_LINES      = 256;
   localparam int N_REQ          = 2;

   // mem_instr encoding
   localparam logic MEM_OP_STORE = 1'b0;
   localparam logic MEM_OP_LOAD  = 1'b1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_e;

   // Replace one REG_LEN word of a cache line.
   function automatic logic [CACHE_LINE_LEN-1:0] merge_word(
      input logic [CACHE_LINE_LEN-1:0] line,
      input logic [WSEL_BITS-1:0]      sel,
      input logic [REG_LEN-1:0]        data
   );
      logic [CACHE_LINE_LEN-1:0] merged;
      merged = line;
      merged[sel*REG_LEN +: REG_LEN] = data;
      return merged;
   endfunction

endpackage

// File: rtl/mem_responder_rr_arbiter2.sv
// Two-input round-robin arbiter; pointer moves to the other requester after each accepted grant.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic r_ptr;

   // Pointer only matters when both requesters are asking in the same cycle.
   always_comb begin
      gnt = '0;
      if (req == 2'b11) begin
         gnt = r_ptr ? 2'b10 : 2'b01;
      end else begin
         gnt = req;
      end
   end

   // Point at the requester that did not win, once the grant is actually taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 1'b0;
      end else if (advance && (|gnt)) begin
         r_ptr <= gnt[0];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for icache/dcache misses and write-through stores: one transaction at a time.
module mem_responder
   import brisc_pkg::*;
#(
   parameter int LATENCY = MEM_LATENCY,
   parameter int LINES   = MEM_LINES
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [N_REQ-1:0]                     mem_req,
   input  logic [N_REQ-1:0]                     mem_instr,
   input  logic [N_REQ-1:0][TAG_BITS-1:0]       p_address,
   input  logic [N_REQ-1:0][WSEL_BITS-1:0]      word_sel,
   input  logic [N_REQ-1:0][REG_LEN-1:0]        wdata,
   output logic [N_REQ-1:0]                     grant,
   output logic [N_REQ-1:0]                     mem_resp,
   output logic [CACHE_LINE_LEN-1:0]            fill
);

   localparam int LINE_BITS = $clog2(LINES);
   localparam int CNT_BITS  = 4;
   // Grant cycle and response cycle are both outside BUSY, hence the -2.
   localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(LATENCY - 2);

   mem_state_e                r_state;
   mem_state_e                w_state_next;
   logic [CNT_BITS-1:0]       r_cnt;
   logic                      r_id;
   logic                      r_instr;
   logic [LINE_BITS-1:0]      r_line;
   logic [WSEL_BITS-1:0]      r_wsel;
   logic [REG_LEN-1:0]        r_wdata;
   logic [N_REQ-1:0]          r_resp;
   logic [CACHE_LINE_LEN-1:0] r_fill;
   logic [CACHE_LINE_LEN-1:0] r_rd_line;
   logic [CACHE_LINE_LEN-1:0] r_mem [LINES];

   logic [N_REQ-1:0]          w_arb_gnt;
   logic                      w_take;
   logic                      w_gnt_id;
   logic                      w_last;
   logic [LINE_BITS-1:0]      w_req_line;
   logic [CACHE_LINE_LEN-1:0] w_merged;
   logic                      w_unused_addr_hi;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (mem_req),
      .advance (w_take),
      .gnt     (w_arb_gnt)
   );

   assign w_take     = |grant;
   assign w_gnt_id   = grant[1];
   assign w_last     = (r_state == BUSY) && (r_cnt == '0);
   // Only the low line-index bits address the array; the rest wrap.
   assign w_req_line = p_address[w_gnt_id][LINE_BITS-1:0];
   assign w_unused_addr_hi = ^{p_address[0][TAG_BITS-1:LINE_BITS], p_address[1][TAG_BITS-1:LINE_BITS]};
   assign w_merged   = (r_instr == MEM_OP_STORE) ? merge_word(r_rd_line, r_wsel, r_wdata) : r_rd_line;

   assign mem_resp = r_resp;
   assign fill     = r_fill;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state; grant is offered only while idle and out of reset.
   always_comb begin
      w_state_next = r_state;
      grant        = '0;
      case (r_state)
         IDLE: begin
            if (rst_n) begin
               grant = w_arb_gnt;
            end
            if (|grant) begin
               w_state_next = BUSY;
            end
         end
         BUSY: begin
            if (r_cnt == '0) begin
               w_state_next = RESP;
            end
         end
         RESP:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Capture the granted request, count down the latency, and register the response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_id    <= 1'b0;
         r_instr <= 1'b0;
         r_line  <= '0;
         r_wsel  <= '0;
         r_wdata <= '0;
         r_resp  <= '0;
         r_fill  <= '0;
      end else begin
         r_resp <= '0;
         if (w_take) begin
            r_id    <= w_gnt_id;
            r_instr <= mem_instr[w_gnt_id];
            r_line  <= w_req_line;
            r_wsel  <= word_sel[w_gnt_id];
            r_wdata <= wdata[w_gnt_id];
            r_cnt   <= CNT_INIT;
         end else if ((r_state == BUSY) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_last) begin
            r_resp[r_id] <= 1'b1;
            r_fill       <= w_merged;
         end
      end
   end

   // Backing array: line read registered at grant, merged store written back with the response.
   always_ff @(posedge clk) begin
      if (w_take) begin
         r_rd_line <= r_mem[w_req_line];
      end
      if (w_last && (r_instr == MEM_OP_STORE)) begin
         r_mem[r_line] <= w_merged;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder with a cycle-accurate transaction model and directed literal checks.
module tb_mem_responder;
   import brisc_pkg::*;

   localparam int LAT   = 5;
   localparam int LINES = 256;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   logic [1:0]                 mem_req   = '0;
   logic [1:0]                 mem_instr = '0;
   logic [1:0][TAG_BITS-1:0]   p_address = '0;
   logic [1:0][WSEL_BITS-1:0]  word_sel  = '0;
   logic [1:0][REG_LEN-1:0]    wdata     = '0;
   logic [1:0]                 grant;
   logic [1:0]                 mem_resp;
   logic [CACHE_LINE_LEN-1:0]  fill;

   // Second instance built with the minimum latency.
   logic [1:0]                 req_b     = '0;
   logic [1:0]                 instr_b   = '0;
   logic [1:0][TAG_BITS-1:0]   addr_b    = '0;
   logic [1:0][WSEL_BITS-1:0]  wsel_b    = '0;
   logic [1:0][REG_LEN-1:0]    wdata_b   = '0;
   logic [1:0]                 grant_b;
   logic [1:0]                 resp_b;
   logic [CACHE_LINE_LEN-1:0]  fill_b_unused;

   mem_responder #(.LATENCY(LAT), .LINES(LINES)) dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_instr(mem_instr),
      .p_address(p_address), .word_sel(word_sel), .wdata(wdata),
      .grant(grant), .mem_resp(mem_resp), .fill(fill)
   );

   mem_responder #(.LATENCY(2), .LINES(LINES)) dut_b (
      .clk(clk), .rst_n(rst_n), .mem_req(req_b), .mem_instr(instr_b),
      .p_address(addr_b), .word_sel(wsel_b), .wdata(wdata_b),
      .grant(grant_b), .mem_resp(resp_b), .fill(fill_b_unused)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   bit check_fill = 1'b0;

   // Behavioural model: one outstanding transaction, response LAT cycles after grant.
   logic [CACHE_LINE_LEN-1:0] m_mem [LINES];
   logic [CACHE_LINE_LEN-1:0] m_fill;
   logic [CACHE_LINE_LEN-1:0] m_line_val;
   int   m_free, m_resp_cyc, m_ptr, m_id, m_line, m_wsel, g_id;
   logic m_instr;
   logic [REG_LEN-1:0] m_wdata;
   logic [1:0] e_gnt, e_resp;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic do_req(input int id, input logic instr, input logic [TAG_BITS-1:0] addr,
                         input logic [WSEL_BITS-1:0] ws, input logic [REG_LEN-1:0] wd,
                         output int gcyc, output int rcyc, output logic [127:0] rfill);
      @(posedge clk); #1;
      mem_instr[id] = instr;
      p_address[id] = addr;
      word_sel[id]  = ws;
      wdata[id]     = wd;
      mem_req[id]   = 1'b1;
      gcyc = -1; rcyc = -1; rfill = '0;
      for (int i = 0; i < 200 && gcyc < 0; i++) begin
         @(negedge clk);
         if (grant[id]) gcyc = cyc;
      end
      @(posedge clk); #1;
      mem_req[id] = 1'b0;
      for (int i = 0; i < 50 && rcyc < 0 && gcyc >= 0; i++) begin
         @(negedge clk);
         if (mem_resp[id]) begin
            rcyc  = cyc;
            rfill = fill;
         end
      end
      chk("req_timeout", 128'(gcyc < 0 || rcyc < 0), 128'd0);
   endtask

   int gc, rc;
   logic [127:0] rf;
   logic [127:0] saved;
   int g_cyc[$];
   int g_ids[$];
   int r_cnt_seen;
   logic [127:0] first_fill;
   int t0;
   int gb[$];
   int rb[$];

   initial begin
      m_free = 0; m_resp_cyc = -1; m_ptr = 0; m_fill = '0;
      for (int k = 0; k < LINES; k++) m_mem[k] = '0;

      fork
         // Per-cycle comparison against the model.
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               chk("rst_grant", 128'(grant), 128'd0);
               chk("rst_resp", 128'(mem_resp), 128'd0);
               chk("rst_fill", fill, 128'd0);
               m_free = 0; m_resp_cyc = -1; m_ptr = 0; m_fill = '0;
            end else begin
               e_resp = '0;
               if (cyc == m_resp_cyc) begin
                  m_line_val = m_mem[m_line];
                  if (m_instr == MEM_OP_STORE) m_line_val[m_wsel*REG_LEN +: REG_LEN] = m_wdata;
                  m_mem[m_line] = m_line_val;
                  m_fill = m_line_val;
                  e_resp[m_id] = 1'b1;
                  m_resp_cyc = -1;
               end
               e_gnt = '0;
               if (cyc >= m_free && mem_req != 2'b00) begin
                  if (mem_req == 2'b11) g_id = m_ptr;
                  else g_id = mem_req[1] ? 1 : 0;
                  e_gnt[g_id] = 1'b1;
                  m_id       = g_id;
                  m_instr    = mem_instr[g_id];
                  m_line     = int'(p_address[g_id]) % LINES;
                  m_wsel     = int'(word_sel[g_id]);
                  m_wdata    = wdata[g_id];
                  m_resp_cyc = cyc + LAT;
                  m_free     = cyc + LAT + 1;
                  m_ptr      = 1 - g_id;
               end
               chk("grant", 128'(grant), 128'(e_gnt));
               chk("mem_resp", 128'(mem_resp), 128'(e_resp));
               if (check_fill) chk("fill", fill, m_fill);
            end
         end
      join_none

      // Reset
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Preload line k = {4{k}} through the store path.
      for (int k = 0; k < LINES; k++)
         for (int w = 0; w < WORDS_PER_LINE; w++)
            do_req(k % 2, MEM_OP_STORE, TAG_BITS'(k), WSEL_BITS'(w), REG_LEN'(k), gc, rc, rf);
      check_fill = 1'b1;

      // Single load
      do_req(0, MEM_OP_LOAD, 3, 0, 0, gc, rc, rf);
      chk("load3_latency", 128'(rc - gc), 128'd5);
      chk("load3_fill", rf, 128'h00000003_00000003_00000003_00000003);

      // Store then load
      do_req(1, MEM_OP_STORE, 7, 2, 32'hDEADBEEF, gc, rc, rf);
      chk("store7_fill", rf, 128'h00000007_DEADBEEF_00000007_00000007);
      do_req(0, MEM_OP_LOAD, 7, 0, 0, gc, rc, rf);
      chk("load7_fill", rf, 128'h00000007_DEADBEEF_00000007_00000007);

      // Address wrap
      do_req(1, MEM_OP_LOAD, TAG_BITS'(LINES + 5), 0, 0, gc, rc, rf);
      chk("wrap_fill", rf, 128'h00000005_00000005_00000005_00000005);

      // Random concurrent traffic from both requesters
      fork
         begin
            int g0, r0; logic [127:0] f0;
            for (int n = 0; n < 40; n++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               do_req(0, 1'($urandom), TAG_BITS'($urandom), WSEL_BITS'($urandom),
                      $urandom, g0, r0, f0);
            end
         end
         begin
            int g1, r1; logic [127:0] f1;
            for (int n = 0; n < 40; n++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               do_req(1, 1'($urandom), TAG_BITS'($urandom), WSEL_BITS'($urandom),
                      $urandom, g1, r1, f1);
            end
         end
      join

      // Reset during BUSY drops a store, then contention from reset exit
      saved = m_mem[9];
      @(posedge clk); #1;
      mem_instr[1] = MEM_OP_STORE; p_address[1] = 9; word_sel[1] = 1; wdata[1] = 32'h12345678;
      mem_req[1] = 1'b1;
      gc = -1;
      for (int i = 0; i < 20 && gc < 0; i++) begin
         @(negedge clk);
         if (grant[1]) gc = cyc;
      end
      chk("midop_grant_seen", 128'(gc >= 0), 128'd1);
      @(posedge clk); #1 mem_req[1] = 1'b0;
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem_instr = 2'b11;
      p_address[0] = 9; p_address[1] = 9;
      mem_req = 2'b11;
      r_cnt_seen = 0; first_fill = '0; t0 = -1;
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         if (t0 < 0) t0 = cyc;
         if (grant != 2'b00) begin
            g_cyc.push_back(cyc);
            g_ids.push_back(grant[1] ? 1 : 0);
         end
         if (mem_resp != 2'b00) begin
            if (r_cnt_seen == 0) first_fill = fill;
            r_cnt_seen++;
         end
      end
      @(posedge clk); #1 mem_req = 2'b00;
      chk("cont_grant_count", 128'(g_cyc.size()), 128'd4);
      chk("cont_resp_count", 128'(r_cnt_seen), 128'd3);
      chk("midop_old_line", first_fill, saved);
      if (g_cyc.size() == 4) begin
         chk("cont_first_at_exit", 128'(g_cyc[0] - t0), 128'd0);
         for (int i = 0; i < 4; i++) begin
            chk("cont_id", 128'(g_ids[i]), 128'(i % 2));
            if (i > 0) chk("cont_gap", 128'(g_cyc[i] - g_cyc[i-1]), 128'd6);
         end
      end
      repeat (10) @(posedge clk);

      // Minimum-latency instance with a held request
      @(posedge clk); #1;
      instr_b = 2'b11;
      req_b = 2'b01;
      t0 = -1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (t0 < 0) t0 = cyc;
         if (grant_b[0]) gb.push_back(cyc);
         if (resp_b[0]) rb.push_back(cyc);
      end
      @(posedge clk); #1 req_b = 2'b00;
      chk("lat2_grant_count", 128'(gb.size()), 128'd3);
      chk("lat2_resp_count", 128'(rb.size()), 128'd2);
      if (gb.size() >= 2 && rb.size() >= 1) begin
         chk("lat2_first_grant", 128'(gb[0] - t0), 128'd0);
         chk("lat2_resp_latency", 128'(rb[0] - gb[0]), 128'd2);
         chk("lat2_next_grant", 128'(gb[1] - gb[0]), 128'd3);
      end

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
